// File: rtl/reg_wb_arbiter_pkg.sv
// rtl/reg_wb_arbiter_pkg.sv - shared types and constants for the writeback arbiter
package reg_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 16;

    localparam logic [REG_ADDR_W-1:0] REG14_ADDR = 4'd14;
    localparam logic [REG_ADDR_W-1:0] REG0_ADDR  = 4'd0;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/reg_wb_arbiter_wb_out_reg.sv
// rtl/reg_wb_arbiter_wb_out_reg.sv - registered register-file write-port stage
module wb_out_reg #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o
);

    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;

    // Address/data hold their last written values between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= en_i;
            if (en_i) begin
                addr_q <= addr_i;
                data_q <= data_i;
            end
        end
    end

    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - ALU/load arbiter for the general write port plus R14 multiply port
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [REG_DATA_W-1:0] alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic [REG_DATA_W-1:0] ld_data,
    input  logic                  m14_valid,
    output logic                  m14_ready,
    input  logic [REG_DATA_W-1:0] m14_data,
    output logic                  reg_we,
    output logic [REG_ADDR_W-1:0] w_addr,
    output logic [REG_DATA_W-1:0] w_data,
    output logic                  reg14_we,
    output logic [REG_DATA_W-1:0] w_reg14,
    output logic                  force_active
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    arb_state_t             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   alu_xfer;
    logic                   ld_xfer;
    logic                   gen_xfer;
    logic                   ld_blocked;
    logic                   m14_xfer;
    logic [REG_ADDR_W-1:0]  gen_addr;
    logic [REG_DATA_W-1:0]  gen_data;
    logic [REG_ADDR_W-1:0]  r14_addr_unused;

    always_comb begin
        alu_ready = 1'b0;
        ld_ready  = 1'b0;
        if (rst) begin
            if (state_q == NORMAL) begin
                alu_ready = 1'b1;
                ld_ready  = ~alu_valid;
            end else begin
                ld_ready  = 1'b1;
                alu_ready = ~ld_valid;
            end
        end
    end

    assign alu_xfer   = alu_valid & alu_ready;
    assign ld_xfer    = ld_valid & ld_ready;
    assign gen_xfer   = alu_xfer | ld_xfer;
    assign ld_blocked = ld_valid & ~ld_ready;
    assign gen_addr   = alu_xfer ? alu_addr : ld_addr;
    assign gen_data   = alu_xfer ? alu_data : ld_data;

    // A general write to R14 takes priority; the multiply retries next cycle
    assign m14_ready = rst & ~(gen_xfer & (gen_addr == REG14_ADDR));
    assign m14_xfer  = m14_valid & m14_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (ld_blocked) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= FORCE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                FORCE: begin
                    cnt_q <= '0;
                    if (ld_xfer || !ld_valid) begin
                        state_q <= NORMAL;
                    end
                end
                default: begin
                    state_q <= NORMAL;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign force_active = (state_q == FORCE);

    wb_out_reg #(
        .AW(REG_ADDR_W),
        .DW(REG_DATA_W)
    ) u_gen_port (
        .clk    (clk),
        .rst_n  (rst),
        .en_i   (gen_xfer && (gen_addr != REG0_ADDR)),
        .addr_i (gen_addr),
        .data_i (gen_data),
        .we_o   (reg_we),
        .addr_o (w_addr),
        .data_o (w_data)
    );

    wb_out_reg #(
        .AW(REG_ADDR_W),
        .DW(REG_DATA_W)
    ) u_r14_port (
        .clk    (clk),
        .rst_n  (rst),
        .en_i   (m14_xfer),
        .addr_i (REG14_ADDR),
        .data_i (m14_data),
        .we_o   (reg14_we),
        .addr_o (r14_addr_unused),
        .data_o (w_reg14)
    );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - self-checking bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, ld_valid, m14_valid;
    logic        alu_ready, ld_ready, m14_ready;
    logic [3:0]  alu_addr, ld_addr;
    logic [15:0] alu_data, ld_data, m14_data;
    logic        reg_we, reg14_we, force_active;
    logic [3:0]  w_addr;
    logic [15:0] w_data, w_reg14;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_force;
    int          m_blk;
    logic        exp_we, exp_we14;
    logic [3:0]  exp_addr;
    logic [15:0] exp_data, exp_w14;
    bit          last_ax, last_lx, last_mx;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .m14_valid(m14_valid), .m14_ready(m14_ready), .m14_data(m14_data),
        .reg_we(reg_we), .w_addr(w_addr), .w_data(w_data),
        .reg14_we(reg14_we), .w_reg14(w_reg14), .force_active(force_active)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_force  = 0;
        m_blk    = 0;
        exp_we   = 0;
        exp_we14 = 0;
        exp_addr = 0;
        exp_data = 0;
        exp_w14  = 0;
        last_ax  = 0;
        last_lx  = 0;
        last_mx  = 0;
    endtask

    // Check one cycle at the falling edge, advance the model, return just after the rising edge
    task automatic step(input string tag);
        bit e_ar, e_lr, e_mr, ax, lx, mx;
        logic [3:0]  ga;
        logic [15:0] gd;
        @(negedge clk);
        e_ar = m_force ? !ld_valid : 1'b1;
        e_lr = m_force ? 1'b1 : !alu_valid;
        chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(e_ar));
        chk({tag, ".ld_ready"}, 32'(ld_ready), 32'(e_lr));
        chk({tag, ".force_active"}, 32'(force_active), 32'(m_force));
        chk({tag, ".reg_we"}, 32'(reg_we), 32'(exp_we));
        if (exp_we) begin
            chk({tag, ".w_addr"}, 32'(w_addr), 32'(exp_addr));
            chk({tag, ".w_data"}, 32'(w_data), 32'(exp_data));
        end
        chk({tag, ".reg14_we"}, 32'(reg14_we), 32'(exp_we14));
        chk({tag, ".w_reg14"}, 32'(w_reg14), 32'(exp_w14));
        ax = alu_valid && e_ar;
        lx = ld_valid && e_lr;
        ga = ax ? alu_addr : ld_addr;
        gd = ax ? alu_data : ld_data;
        e_mr = !((ax || lx) && ga == 4'd14);
        chk({tag, ".m14_ready"}, 32'(m14_ready), 32'(e_mr));
        mx = m14_valid && e_mr;
        exp_we = (ax || lx) && ga != 4'd0;
        if (exp_we) begin
            exp_addr = ga;
            exp_data = gd;
        end
        exp_we14 = mx;
        if (mx) exp_w14 = m14_data;
        if (!m_force) begin
            if (ld_valid && !e_lr) begin
                m_blk++;
                if (m_blk == LIMIT) begin
                    m_force = 1;
                    m_blk   = 0;
                end
            end else begin
                m_blk = 0;
            end
        end else if (lx || !ld_valid) begin
            m_force = 0;
            m_blk   = 0;
        end
        last_ax = ax;
        last_lx = lx;
        last_mx = mx;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_drive();
        if (!(alu_valid && !last_ax)) begin
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_addr  = 4'($urandom);
            alu_data  = 16'($urandom);
        end
        if (!(ld_valid && !last_lx)) begin
            ld_valid = ($urandom_range(0, 1) != 0);
            ld_addr  = 4'($urandom);
            ld_data  = 16'($urandom);
        end
        if (!(m14_valid && !last_mx)) begin
            m14_valid = ($urandom_range(0, 1) != 0);
            m14_data  = 16'($urandom);
        end
    endtask

    initial begin
        model_reset();
        rst       = 1'b0;
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 16'h1234;
        ld_valid  = 1'b1; ld_addr  = 4'd5; ld_data  = 16'hBEEF;
        m14_valid = 1'b1; m14_data = 16'h5555;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.alu_ready", 32'(alu_ready), 32'd0);
        chk("rst.ld_ready", 32'(ld_ready), 32'd0);
        chk("rst.m14_ready", 32'(m14_ready), 32'd0);
        chk("rst.reg_we", 32'(reg_we), 32'd0);
        chk("rst.reg14_we", 32'(reg14_we), 32'd0);
        chk("rst.w_addr", 32'(w_addr), 32'd0);
        chk("rst.w_data", 32'(w_data), 32'd0);
        chk("rst.w_reg14", 32'(w_reg14), 32'd0);
        chk("rst.force_active", 32'(force_active), 32'd0);

        // Release: ALU and load collide, ALU wins; multiply waits out of the way
        @(posedge clk); #1;
        rst = 1'b1;
        m14_valid = 1'b0;
        step("collide");
        chk("collide.reg_we", 32'(reg_we), 32'd1);
        chk("collide.w_addr", 32'(w_addr), 32'd3);
        chk("collide.w_data", 32'(w_data), 32'h1234);

        // Continuous ALU traffic starves the load until forced
        for (int i = 0; i < LIMIT - 1; i++) begin
            alu_addr = 4'd1; alu_data = 16'(16'h0100 + i);
            step("starve");
        end
        chk("starve.force_active", 32'(force_active), 32'd1);
        step("force");
        chk("force.w_addr", 32'(w_addr), 32'd5);
        chk("force.w_data", 32'(w_data), 32'hBEEF);
        chk("force.exit", 32'(force_active), 32'd0);
        ld_valid = 1'b0;
        alu_valid = 1'b0;
        step("idle");

        // R14 conflict between general port and multiply port
        alu_valid = 1'b1; alu_addr = 4'd14; alu_data = 16'h00AA;
        m14_valid = 1'b1; m14_data = 16'h5555;
        step("r14.conflict");
        chk("r14.reg_we", 32'(reg_we), 32'd1);
        chk("r14.w_data", 32'(w_data), 32'h00AA);
        chk("r14.no_we14", 32'(reg14_we), 32'd0);
        alu_valid = 1'b0;
        step("r14.retry");
        chk("r14.reg14_we", 32'(reg14_we), 32'd1);
        chk("r14.w_reg14", 32'(w_reg14), 32'h5555);
        m14_valid = 1'b0;

        // Load to R0 is accepted and dropped
        ld_valid = 1'b1; ld_addr = 4'd0; ld_data = 16'hFFFF;
        step("r0");
        chk("r0.reg_we", 32'(reg_we), 32'd0);
        ld_valid = 1'b0;
        step("r0.idle");

        // Asynchronous reset with a write in flight and a partly aged load
        alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 16'h7777;
        ld_valid  = 1'b1; ld_addr  = 4'd9; ld_data  = 16'h9999;
        step("mid.a");
        step("mid.b");
        chk("mid.reg_we", 32'(reg_we), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid.reg_we_async", 32'(reg_we), 32'd0);
        chk("mid.force_active", 32'(force_active), 32'd0);
        chk("mid.alu_ready", 32'(alu_ready), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        // Counter must restart from zero: load forced only after a full LIMIT blocked cycles
        for (int i = 0; i < LIMIT + 2; i++) step("post_rst");

        alu_valid = 1'b0; ld_valid = 1'b0; m14_valid = 1'b0;
        step("pre_rand");
        for (int i = 0; i < 400; i++) begin
            rand_drive();
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
